regfile_mp_sb: RTL and testbench

- Parametrised multi-port register file for the pipelined core; successor to the single-write 32x32 file.
- Adds a second write port, N configurable read ports, write-to-read bypass and a per-register busy scoreboard for hazard detection.
- Sits between decode (reads, scoreboard set) and writeback (two retire lanes).

---
 rtl/regfile_mp_sb.sv | 123 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass and busy scoreboard
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      wr0_en,
  input  logic [ADDR_W-1:0]         wr0_addr,
  input  logic [DATA_W-1:0]         wr0_data,
  input  logic                      wr1_en,
  input  logic [ADDR_W-1:0]         wr1_addr,
  input  logic [DATA_W-1:0]         wr1_data,
  input  logic                      sb_set_en,
  input  logic [ADDR_W-1:0]         sb_set_addr,
  output logic [(2**ADDR_W)-1:0]    busy_vec,
  output logic                      wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DEPTH-1:0]  r_busy;
  logic              r_wr_conflict;

  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_set_ok;
  logic              w_conflict;

  // Accesses to entry 0 are squashed when it is hardwired, so neither storage,
  // scoreboard nor the collision flag ever sees them.
  assign w_wr0_ok   = wr0_en    && !(ZR && (wr0_addr    == '0));
  assign w_wr1_ok   = wr1_en    && !(ZR && (wr1_addr    == '0));
  assign w_set_ok   = sb_set_en && !(ZR && (sb_set_addr == '0));
  assign w_conflict = w_wr0_ok && w_wr1_ok && (wr0_addr == wr1_addr);

  // Storage update: lane 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= '0;
      end
    end else begin
      if (w_wr0_ok) begin
        r_mem[wr0_addr] <= wr0_data;
      end
      if (w_wr1_ok) begin
        r_mem[wr1_addr] <= wr1_data;
      end
    end
  end

  // Scoreboard next state: a new producer (set) beats a retiring one (clear).
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < DEPTH; j++) begin
      if (w_set_ok && (sb_set_addr == ADDR_W'(j))) begin
        w_busy_nxt[j] = 1'b1;
      end else if ((w_wr0_ok && (wr0_addr == ADDR_W'(j))) ||
                   (w_wr1_ok && (wr1_addr == ADDR_W'(j)))) begin
        w_busy_nxt[j] = 1'b0;
      end
    end
  end

  // Scoreboard and collision flag registers; reset drops every pending producer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy        <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_wr_conflict <= w_conflict;
    end
  end

  assign busy_vec    = r_busy;
  assign wr_conflict = r_wr_conflict;

  generate
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      logic [DATA_W-1:0] w_d;
      logic              w_b;
      logic              w_zero;
      logic              w_hit0;
      logic              w_hit1;

      assign w_a    = rd_addr[g*ADDR_W +: ADDR_W];
      assign w_zero = ZR && (w_a == '0);
      assign w_hit0 = wr0_en && (wr0_addr == w_a);
      assign w_hit1 = wr1_en && (wr1_addr == w_a);

      // Read mux: zero rule, then younger lane, then older lane, then storage.
      always_comb begin
        w_d = r_mem[w_a];
        w_b = r_busy[w_a];
        if (w_zero) begin
          w_d = '0;
          w_b = 1'b0;
        end else if (w_hit1) begin
          w_d = wr1_data;
          w_b = 1'b0;
        end else if (w_hit0) begin
          w_d = wr0_data;
          w_b = 1'b0;
        end
      end

      assign rd_data[g*DATA_W +: DATA_W] = w_d;
      assign rd_busy[g]                  = w_b;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - table-driven scoreboard bench for regfile_mp_sb
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  typedef struct packed {
    logic          rstn;
    logic          w0e;
    logic [AW-1:0] w0a;
    logic [DW-1:0] w0d;
    logic          w1e;
    logic [AW-1:0] w1a;
    logic [DW-1:0] w1d;
    logic          se;
    logic [AW-1:0] sa;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e_rd0;
    logic [DW-1:0] e_rd1;
    logic [1:0]    e_busy;
    logic [31:0]   e_bv;
    logic          e_wc;
    logic [DW-1:0] e_b_rd0;
    logic          e_b_bv0;
    logic          e_b_wc;
  } vec_t;

  logic             clk;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_a, rd_data_b;
  logic [NR-1:0]    rd_busy_a, rd_busy_b;
  logic             wr0_en, wr1_en, sb_set_en;
  logic [AW-1:0]    wr0_addr, wr1_addr, sb_set_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic [31:0]      busy_vec_a, busy_vec_b;
  logic             wr_conflict_a, wr_conflict_b;

  int n_checks = 0;
  int n_errors = 0;
  vec_t q_exp[$];
  vec_t tbl[0:19];

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .busy_vec(busy_vec_a), .wr_conflict(wr_conflict_a)
  );

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .busy_vec(busy_vec_b), .wr_conflict(wr_conflict_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive after the edge, queue the expectation, sample mid-cycle.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    reset       = v.rstn;
    wr0_en      = v.w0e;
    wr0_addr    = v.w0a;
    wr0_data    = v.w0d;
    wr1_en      = v.w1e;
    wr1_addr    = v.w1a;
    wr1_data    = v.w1d;
    sb_set_en   = v.se;
    sb_set_addr = v.sa;
    rd_addr     = {v.ra1, v.ra0};
    q_exp.push_back(v);
    #3;
    e = q_exp.pop_front();
    chk("a_rd0",  idx, rd_data_a[DW-1:0],    e.e_rd0);
    chk("a_rd1",  idx, rd_data_a[2*DW-1:DW], e.e_rd1);
    chk("a_busy", idx, 32'(rd_busy_a),       32'(e.e_busy));
    chk("a_bv",   idx, busy_vec_a,           e.e_bv);
    chk("a_wc",   idx, 32'(wr_conflict_a),   32'(e.e_wc));
    chk("b_rd0",  idx, rd_data_b[DW-1:0],    e.e_b_rd0);
    chk("b_bv0",  idx, 32'(busy_vec_b[0]),   32'(e.e_b_bv0));
    chk("b_wc",   idx, 32'(wr_conflict_b),   32'(e.e_b_wc));
  endtask

  initial begin
    vec_t v;
    //        rst  w0e  w0a    w0d            w1e  w1a    w1d         se   sa     ra0    ra1    e_rd0          e_rd1          busy   e_bv           wc   b_rd0          b_bv0 b_wc
    tbl[0]  = '{1'b1,1'b1,5'd3, 32'hDEADBEEF,1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd3, 5'd0, 32'hDEADBEEF,32'h0,       2'b00,32'h0,       1'b0,32'hDEADBEEF,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd3, 5'd7, 32'hDEADBEEF,32'h0,       2'b00,32'h0,       1'b0,32'hDEADBEEF,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,5'd7, 32'h11,      1'b1,5'd7, 32'h22,     1'b0,5'd0, 5'd7, 5'd3, 32'h22,      32'hDEADBEEF,2'b00,32'h0,       1'b0,32'h22,      1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd7, 5'd7, 32'h22,      32'h22,      2'b00,32'h0,       1'b1,32'h22,      1'b0,1'b1};
    tbl[4]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd7, 5'd3, 32'h22,      32'hDEADBEEF,2'b00,32'h0,       1'b0,32'h22,      1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b1,5'd5, 5'd5, 5'd3, 32'h0,       32'hDEADBEEF,2'b00,32'h0,       1'b0,32'h0,       1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd5, 5'd5, 32'h0,       32'h0,       2'b11,32'h20,      1'b0,32'h0,       1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b1,5'd5, 32'h55,     1'b0,5'd0, 5'd5, 5'd3, 32'h55,      32'hDEADBEEF,2'b00,32'h20,      1'b0,32'h55,      1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd5, 5'd3, 32'h55,      32'hDEADBEEF,2'b00,32'h0,       1'b0,32'h55,      1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,5'd5, 32'h66,      1'b0,5'd0, 32'h0,      1'b1,5'd5, 5'd5, 5'd5, 32'h66,      32'h66,      2'b00,32'h0,       1'b0,32'h66,      1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd5, 5'd9, 32'h66,      32'h0,       2'b01,32'h20,      1'b0,32'h66,      1'b0,1'b0};
    tbl[11] = '{1'b1,1'b1,5'd0, 32'hFFFFFFFF,1'b0,5'd0, 32'h0,      1'b1,5'd0, 5'd0, 5'd5, 32'h0,       32'h66,      2'b10,32'h20,      1'b0,32'hFFFFFFFF,1'b0,1'b0};
    tbl[12] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd0, 5'd0, 32'h0,       32'h0,       2'b00,32'h20,      1'b0,32'hFFFFFFFF,1'b1,1'b0};
    tbl[13] = '{1'b1,1'b1,5'd0, 32'h1,       1'b1,5'd0, 32'h2,      1'b0,5'd0, 5'd0, 5'd5, 32'h0,       32'h66,      2'b10,32'h20,      1'b0,32'h2,       1'b1,1'b0};
    tbl[14] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd0, 5'd5, 32'h0,       32'h66,      2'b10,32'h20,      1'b0,32'h2,       1'b0,1'b1};
    tbl[15] = '{1'b1,1'b1,5'd9, 32'hA5,      1'b0,5'd0, 32'h0,      1'b1,5'd9, 5'd9, 5'd5, 32'hA5,      32'h66,      2'b10,32'h20,      1'b0,32'hA5,      1'b0,1'b0};
    tbl[16] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd9, 5'd5, 32'hA5,      32'h66,      2'b11,32'h220,     1'b0,32'hA5,      1'b0,1'b0};
    tbl[17] = '{1'b0,1'b1,5'd9, 32'h5A,      1'b1,5'd9, 32'h3C,     1'b0,5'd0, 5'd9, 5'd5, 32'h3C,      32'h66,      2'b10,32'h220,     1'b0,32'h3C,      1'b0,1'b0};
    tbl[18] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd9, 5'd5, 32'h0,       32'h0,       2'b00,32'h0,       1'b0,32'h0,       1'b0,1'b0};
    tbl[19] = '{1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,      1'b0,5'd0, 5'd3, 5'd7, 32'h0,       32'h0,       2'b00,32'h0,       1'b0,32'h0,       1'b0,1'b0};

    reset = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; sb_set_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0; sb_set_addr = '0;
    wr0_data = '0; wr1_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);

    // After reset every address reads zero and idle on all ports of both variants.
    for (int a = 0; a < 32; a++) begin
      v = '0;
      v.rstn = 1'b1;
      v.ra0  = AW'(a);
      v.ra1  = AW'(31 - a);
      run_vec(v, 100 + a);
    end

    for (int i = 0; i < 20; i++) begin
      run_vec(tbl[i], i);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
